// File: rtl/line_mem_pkg.sv
// Shared types and geometry for the line memory responder.
// Range checking is enabled by defining LINE_MEM_RANGE_CHECK_EN.
package line_mem_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned OFF_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_mem_sram.sv
// Single-port line store: synchronous write, combinational read.
// Contents survive reset so a bench may preload them.
module line_mem_sram
    import line_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned LINE_W = line_mem_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] memory [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[idx_i];

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder for a cache controller (IDLE/WAIT/ACK).
// Define LINE_MEM_RANGE_CHECK_EN to flag and suppress requests with addr_i[31:14] != 0.
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LINE_W  = line_mem_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              err_o
);

    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] rdata;
    logic              req_err;
    logic              wait_done;
    logic              mem_we;
    logic              unused_addr;

`ifdef LINE_MEM_RANGE_CHECK_EN
    assign req_err = |addr_i[31:IDX_W+OFF_W];
`else
    assign req_err = 1'b0;
`endif

    assign unused_addr = ^{addr_i[31:IDX_W+OFF_W], addr_i[OFF_W-1:0]};

    assign wait_done = (state == WAIT) && (cnt == '0);

    // Commit on the edge that leaves ACK; a coincident reset suppresses it.
    assign mem_we = (state == ACK) && wr_q && !err_q && !rst_i;

    line_mem_sram #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .wdata_i (line_q),
        .rdata_o (rdata)
    );

    // ack_o/err_o/data_o are registered on the WAIT->ACK edge so they are valid for the whole ACK cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            data_o <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ack_o <= wait_done;
            err_o <= wait_done & err_q;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        wr_q   <= write_i;
                        err_q  <= req_err;
                        idx_q  <= addr_i[IDX_W+OFF_W-1:OFF_W];
                        line_q <= data_i;
                        cnt    <= CNT_LOAD;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACK;
                        if (!wr_q) begin
                            data_o <= err_q ? '0 : rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
